mod_n_up_counter: RTL and testbench

//  Parameterised modulo-N up counter; the count-up counterpart of the team's 4-bit down counter.

---
 rtl/counters_pkg.sv | 12 +
 rtl/sticky_flag.sv | 32 +++
 rtl/mod_n_up_counter.sv | 120 ++++++++++++
 tb/tb_mod_n_up_counter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counters_pkg.sv
// counters_pkg: shared definitions for the COUNTERS library.
// Holds the run/enable FSM state encoding used by the up/down counters and
// the timer blocks built on top of them.
package counters_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cnt_state_e;

endpackage

// File: rtl/sticky_flag.sv
// sticky_flag: single sticky status bit with set / acknowledge / clear.
//   clk, reset : clock and asynchronous active-high reset
//   clr_i      : synchronous clear, highest priority
//   set_i      : sets the flag; wins over a simultaneous ack
//   ack_i      : clears the flag when no set is present
//   flag_o     : registered flag
module sticky_flag (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic set_i,
  input  logic ack_i,
  output logic flag_o
);

  logic flag_q, flag_d;

  always_comb begin
    flag_d = flag_q;
    if (clr_i)      flag_d = 1'b0;
    else if (set_i) flag_d = 1'b1;  // an event arriving with the ack is not lost
    else if (ack_i) flag_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flag_q <= 1'b0;
    else       flag_q <= flag_d;
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/mod_n_up_counter.sv
// mod_n_up_counter: parameterised modulo-N up counter (0..MODULUS-1).
// Free-running (wrap) or one-shot (stop at top) under an IDLE/RUN/DONE FSM.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : sync clear -> count 0, IDLE, flags cleared
//   start      : IDLE/DONE -> RUN with count 0 (ignored in RUN)
//   en         : count enable, only effective in RUN
//   oneshot    : 1 stop in DONE at top, 0 wrap to 0
//   load       : sync load of min(load_val, MODULUS-1), state unchanged
//   load_val   : load value
//   cmp_val    : compare value for match
//   ovf_ack    : clears ovf (a simultaneous wrap keeps it set)
//   count      : registered count
//   busy       : state == RUN
//   tc         : combinational cascade carry, busy & en & top
//   wrap, done : registered one-cycle pulses after wrap / entry to DONE
//   match      : registered (count == cmp_val) of the previous cycle
//   ovf        : sticky wrap indicator
module mod_n_up_counter
  import counters_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             start,
  input  logic             en,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             ovf_ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             wrap,
  output logic             done,
  output logic             match,
  output logic             ovf
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("mod_n_up_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  cnt_state_e       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             match_q, match_d;
  logic             at_top;

  // Wrap is decided against TOP, never by natural overflow of the adder.
  assign at_top = (count_q == TOP);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    if (clr) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (load) begin
      count_d = (load_val > TOP) ? TOP : load_val;
    end else if (start && state_q != ST_RUN) begin
      state_d = ST_RUN;
      count_d = '0;
    end else if (state_q == ST_RUN && en) begin
      if (!at_top) begin
        count_d = count_q + WIDTH'(1);
      end else if (oneshot) begin
        state_d = ST_DONE;  // count holds at TOP
        done_d  = 1'b1;
      end else begin
        count_d = '0;
        wrap_d  = 1'b1;
      end
    end
  end

  // match tracks the count regardless of state, one cycle late.
  assign match_d = (count_q == cmp_val);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  sticky_flag u_ovf (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (clr),
    .set_i  (wrap_d),
    .ack_i  (ovf_ack),
    .flag_o (ovf)
  );

  assign count = count_q;
  assign busy  = (state_q == ST_RUN);
  assign tc    = busy & en & at_top;
  assign wrap  = wrap_q;
  assign done  = done_q;
  assign match = match_q;

endmodule

// File: tb/tb_mod_n_up_counter.sv
module tb_mod_n_up_counter;

  logic       clk, reset, clr, start, en, oneshot, load, ovf_ack;
  logic [3:0] load_val, cmp_val;

  logic [3:0] c16, c10;
  logic       busy16, tc16, wrap16, done16, match16, ovf16;
  logic       busy10, tc10, wrap10, done10, match10, ovf10;

  int nchk = 0;
  int nfail = 0;

  // {count, busy, tc, wrap, done, ovf}
  logic [8:0] obs16;
  assign obs16 = {c16, busy16, tc16, wrap16, done16, ovf16};

  mod_n_up_counter #(.WIDTH(4), .MODULUS(16)) u16 (
    .clk(clk), .reset(reset), .clr(clr), .start(start), .en(en),
    .oneshot(oneshot), .load(load), .load_val(load_val), .cmp_val(cmp_val),
    .ovf_ack(ovf_ack), .count(c16), .busy(busy16), .tc(tc16), .wrap(wrap16),
    .done(done16), .match(match16), .ovf(ovf16)
  );

  mod_n_up_counter #(.WIDTH(4), .MODULUS(10)) u10 (
    .clk(clk), .reset(reset), .clr(clr), .start(start), .en(en),
    .oneshot(oneshot), .load(load), .load_val(load_val), .cmp_val(cmp_val),
    .ovf_ack(ovf_ack), .count(c10), .busy(busy10), .tc(tc10), .wrap(wrap10),
    .done(done10), .match(match10), .ovf(ovf10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clr();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    nchk++;
    if (obs16 !== 9'b0 || match16 !== 1'b0) begin
      nfail++; $display("FAIL reset_held got %h/%b exp 000/0", obs16, match16);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    tick();
    nchk++;
    if (obs16 !== 9'b0 || c10 !== 4'd0) begin
      nfail++; $display("FAIL reset_release got %h c10=%0d exp 000 c10=0", obs16, c10);
    end
  endtask

  task automatic test_count_wrap();
    oneshot = 1'b0; en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      nchk++;
      if (obs16 !== {4'(i), 1'b1, (i == 15), 3'b000}) begin
        nfail++; $display("FAIL run16 i=%0d got %h exp %h", i, obs16, {4'(i), 1'b1, (i == 15), 3'b000});
      end
      tick();
    end
    nchk++;
    if (obs16 !== {4'd0, 5'b10101}) begin
      nfail++; $display("FAIL wrap16 got %h exp %h", obs16, {4'd0, 5'b10101});
    end
    tick();
    nchk++;
    if (obs16 !== {4'd1, 5'b10001}) begin
      nfail++; $display("FAIL after_wrap16 got %h exp %h", obs16, {4'd1, 5'b10001});
    end
    en = 1'b0;
  endtask

  task automatic test_mod10();
    do_clr();
    nchk++;
    if (c10 !== 4'd0 || busy10 !== 1'b0 || ovf10 !== 1'b0 || ovf16 !== 1'b0) begin
      nfail++; $display("FAIL clr10 got c=%0d b=%b o=%b o16=%b exp 0/0/0/0", c10, busy10, ovf10, ovf16);
    end
    start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      nchk++;
      if (c10 !== 4'(i) || tc10 !== (i == 9) || wrap10 !== 1'b0) begin
        nfail++; $display("FAIL run10 i=%0d got c=%0d tc=%b w=%b", i, c10, tc10, wrap10);
      end
      tick();
    end
    nchk++;
    if (c10 !== 4'd0 || wrap10 !== 1'b1 || ovf10 !== 1'b1) begin
      nfail++; $display("FAIL wrap10 got c=%0d w=%b o=%b exp 0/1/1", c10, wrap10, ovf10);
    end
    load = 1'b1; load_val = 4'd12;
    tick();
    load = 1'b0;
    nchk++;
    if (c10 !== 4'd9 || wrap10 !== 1'b0 || c16 !== 4'd12) begin
      nfail++; $display("FAIL load12 got c10=%0d w=%b c16=%0d exp 9/0/12", c10, wrap10, c16);
    end
    tick();
    nchk++;
    if (c10 !== 4'd0 || wrap10 !== 1'b1) begin
      nfail++; $display("FAIL rewrap10 got c=%0d w=%b exp 0/1", c10, wrap10);
    end
    en = 1'b0;
    load = 1'b1; load_val = 4'd15;
    tick();
    load = 1'b0;
    nchk++;
    if (c10 !== 4'd9 || c16 !== 4'd15) begin
      nfail++; $display("FAIL load15 got c10=%0d c16=%0d exp 9/15", c10, c16);
    end
    load = 1'b1; load_val = 4'd10;
    tick();
    load = 1'b0;
    nchk++;
    if (c10 !== 4'd9 || c16 !== 4'd10) begin
      nfail++; $display("FAIL load10 got c10=%0d c16=%0d exp 9/10", c10, c16);
    end
  endtask

  task automatic test_oneshot();
    do_clr();
    oneshot = 1'b1; start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    nchk++;
    if (obs16 !== {4'd15, 5'b11000}) begin
      nfail++; $display("FAIL os_top got %h exp %h", obs16, {4'd15, 5'b11000});
    end
    tick();
    nchk++;
    if (obs16 !== {4'd15, 5'b00010}) begin
      nfail++; $display("FAIL os_done got %h exp %h", obs16, {4'd15, 5'b00010});
    end
    tick();
    nchk++;
    if (obs16 !== {4'd15, 5'b00000}) begin
      nfail++; $display("FAIL os_hold1 got %h exp %h", obs16, {4'd15, 5'b00000});
    end
    tick();
    nchk++;
    if (obs16 !== {4'd15, 5'b00000}) begin
      nfail++; $display("FAIL os_hold2 got %h exp %h", obs16, {4'd15, 5'b00000});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    nchk++;
    if (obs16 !== {4'd0, 5'b10000}) begin
      nfail++; $display("FAIL os_restart got %h exp %h", obs16, {4'd0, 5'b10000});
    end
    en = 1'b0; oneshot = 1'b0;
  endtask

  task automatic test_enable_clr();
    do_clr();
    start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    nchk++;
    if (obs16 !== {4'd3, 5'b10000}) begin
      nfail++; $display("FAIL en_run got %h exp %h", obs16, {4'd3, 5'b10000});
    end
    en = 1'b0;
    repeat (2) tick();
    nchk++;
    if (obs16 !== {4'd3, 5'b10000}) begin
      nfail++; $display("FAIL en_hold got %h exp %h", obs16, {4'd3, 5'b10000});
    end
    load = 1'b1; load_val = 4'd15;
    tick();
    load = 1'b0;
    nchk++;
    if (obs16 !== {4'd15, 5'b10000}) begin
      nfail++; $display("FAIL en0_top got %h exp %h", obs16, {4'd15, 5'b10000});
    end
    en = 1'b1;
    #1;
    nchk++;
    if (tc16 !== 1'b1) begin
      nfail++; $display("FAIL en1_tc got %b exp 1", tc16);
    end
    tick();
    nchk++;
    if (obs16 !== {4'd0, 5'b10101}) begin
      nfail++; $display("FAIL en_wrap got %h exp %h", obs16, {4'd0, 5'b10101});
    end
    repeat (7) tick();
    nchk++;
    if (obs16 !== {4'd7, 5'b10001}) begin
      nfail++; $display("FAIL en_at7 got %h exp %h", obs16, {4'd7, 5'b10001});
    end
    do_clr();
    nchk++;
    if (obs16 !== 9'b0) begin
      nfail++; $display("FAIL clr_at7 got %h exp 000", obs16);
    end
    en = 1'b0;
  endtask

  task automatic test_ovf_match();
    cmp_val = 4'd5;
    do_clr();
    start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      nchk++;
      if (c16 !== 4'(i) || match16 !== (i == 6)) begin
        nfail++; $display("FAIL match i=%0d got c=%0d m=%b exp m=%b", i, c16, match16, (i == 6));
      end
      if (i == 15) ovf_ack = 1'b1;
      tick();
    end
    nchk++;
    if (obs16 !== {4'd0, 5'b10101}) begin
      nfail++; $display("FAIL ack_with_wrap got %h exp %h", obs16, {4'd0, 5'b10101});
    end
    tick();
    ovf_ack = 1'b0;
    nchk++;
    if (obs16 !== {4'd1, 5'b10000}) begin
      nfail++; $display("FAIL ack_after got %h exp %h", obs16, {4'd1, 5'b10000});
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    cmp_val = 4'd10;
    do_clr();
    start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    nchk++;
    if (c16 !== 4'd11 || match16 !== 1'b1) begin
      nfail++; $display("FAIL pre_reset got c=%0d m=%b exp 11/1", c16, match16);
    end
    #2 reset = 1'b1;
    #1;
    nchk++;
    if (obs16 !== 9'b0 || match16 !== 1'b0 || c10 !== 4'd0) begin
      nfail++; $display("FAIL async_reset got %h m=%b c10=%0d exp 000/0/0", obs16, match16, c10);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) tick();
    nchk++;
    if (obs16 !== 9'b0) begin
      nfail++; $display("FAIL post_reset_idle got %h exp 000", obs16);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    nchk++;
    if (obs16 !== {4'd0, 5'b10000}) begin
      nfail++; $display("FAIL post_reset_start got %h exp %h", obs16, {4'd0, 5'b10000});
    end
    en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; start = 1'b0; en = 1'b0; oneshot = 1'b0;
    load = 1'b0; ovf_ack = 1'b0; load_val = 4'd0; cmp_val = 4'd5;
    test_reset();
    test_count_wrap();
    test_mod10();
    test_oneshot();
    test_enable_clr();
    test_ovf_match();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
